// File: rtl/data_mem_ctrl_if.sv
// CPU data-port bundle between the core (master) and data_mem_ctrl (slave).
// Carries the request fields plus the ready/rvalid/err response signals.
interface data_mem_ctrl_if;
  logic        req;
  logic [31:0] data_addr;
  logic [31:0] data_write;
  logic [2:0]  MemOp;
  logic        MemWe;
  logic        ready;
  logic [31:0] data_read;
  logic        rvalid;
  logic        err;

  modport master (
    output req, data_addr, data_write, MemOp, MemWe,
    input  ready, data_read, rvalid, err
  );

  modport slave (
    input  req, data_addr, data_write, MemOp, MemWe,
    output ready, data_read, rvalid, err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory controller: 4 KiB word RAM behind a single-outstanding request FSM.
// Handles byte/halfword/word loads with extension and sub-word stores via read-merge-write.
module data_mem_ctrl (
  input  logic           clock,
  input  logic           reset,
  data_mem_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LRESP = 3'd2,
    S_WRITE = 3'd3,
    S_MERGE = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  op_q, op_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] data_read_q, data_read_d;
  logic [31:0] mem_q [0:1023];

  logic        accept_s;
  logic [31:0] ram_rd_s;
  logic [31:0] mem_wdata_s;
  logic        mem_we_s;
  logic        ready_s;
  logic        rvalid_s;
  logic        err_s;
  logic        unused_addr_s;

  // Misaligned accesses, undefined opcodes and unsigned-store encodings are rejected.
  function automatic logic req_invalid(input logic [2:0] op, input logic we, input logic [1:0] off);
    logic inv;
    case (op)
      3'b000:  inv = 1'b0;
      3'b001:  inv = off[0];
      3'b010:  inv = (off != 2'b00);
      3'b100:  inv = we;
      3'b101:  inv = we | off[0];
      default: inv = 1'b1;
    endcase
    return inv;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] op,
                                              input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (op)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Full-word stores fall through to the default and replace the whole word.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [2:0] op, input logic [1:0] off);
    logic [31:0] m;
    m = word;
    case (op)
      3'b000:  m[{off, 3'b000} +: 8]    = wdata[7:0];
      3'b001:  m[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: m = wdata;
    endcase
    return m;
  endfunction

  assign accept_s      = (state_q == S_IDLE) && bus.req;
  assign ram_rd_s      = mem_q[addr_q[11:2]];
  assign mem_wdata_s   = store_merge(rdata_q, wdata_q, op_q, addr_q[1:0]);
  assign mem_we_s      = !reset && ((state_q == S_WRITE) || (state_q == S_MERGE));
  assign unused_addr_s = ^bus.data_addr[31:12];

  // State and request/data registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= 12'h000;
      wdata_q     <= 32'h0000_0000;
      op_q        <= 3'b000;
      we_q        <= 1'b0;
      rdata_q     <= 32'h0000_0000;
      data_read_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      op_q        <= op_d;
      we_q        <= we_d;
      rdata_q     <= rdata_d;
      data_read_q <= data_read_d;
    end
  end

  // RAM write port; reset suppresses any write still pending in WRITE/MERGE
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_q[addr_q[11:2]] <= mem_wdata_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          if (req_invalid(bus.MemOp, bus.MemWe, bus.data_addr[1:0])) begin
            state_d = S_ERR;
          end else if (bus.MemWe && (bus.MemOp == 3'b010)) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (we_q) begin
          state_d = S_MERGE;
        end else begin
          state_d = S_LRESP;
        end
      end
      S_LRESP: state_d = S_IDLE;
      S_WRITE: state_d = S_IDLE;
      S_MERGE: state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture and read-data next state; load result lands as LRESP begins
  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    op_d        = op_q;
    we_d        = we_q;
    rdata_d     = rdata_q;
    data_read_d = data_read_q;
    if (accept_s) begin
      addr_d  = bus.data_addr[11:0];
      wdata_d = bus.data_write;
      op_d    = bus.MemOp;
      we_d    = bus.MemWe;
    end else begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      op_d    = op_q;
      we_d    = we_q;
    end
    if (state_q == S_FETCH) begin
      rdata_d = ram_rd_s;
    end else begin
      rdata_d = rdata_q;
    end
    if ((state_q == S_FETCH) && !we_q) begin
      data_read_d = load_extend(ram_rd_s, op_q, addr_q[1:0]);
    end else begin
      data_read_d = data_read_q;
    end
  end

  // Output decode; completion is withheld in a cycle where reset aborts the request
  always_comb begin
    ready_s  = 1'b0;
    rvalid_s = 1'b0;
    err_s    = 1'b0;
    case (state_q)
      S_IDLE:  ready_s = 1'b1;
      S_LRESP: rvalid_s = !reset;
      S_WRITE: rvalid_s = !reset;
      S_MERGE: rvalid_s = !reset;
      S_ERR: begin
        rvalid_s = !reset;
        err_s    = !reset;
      end
      default: ready_s = 1'b0;
    endcase
  end

  assign bus.ready     = ready_s;
  assign bus.rvalid    = rvalid_s;
  assign bus.err       = err_s;
  assign bus.data_read = data_read_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: a reference memory model predicts each response,
// a negedge monitor pops and compares on every rvalid.
module tb_data_mem_ctrl;

  typedef struct {
    string       tag;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;
  data_mem_ctrl_if bus();

  data_mem_ctrl dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb_q[$];
  logic [31:0] mdl [0:1023];
  logic [31:0] last_load;
  int          n_cmp;
  int          n_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdl_load(input logic [31:0] w, input logic [2:0] op,
                                           input logic [1:0] off);
    logic [31:0] s;
    s = w >> (8 * off);
    if (op == 3'b000) return s[7] ? ((s & 32'h0000_00FF) | 32'hFFFF_FF00) : (s & 32'h0000_00FF);
    else if (op == 3'b001) return s[15] ? ((s & 32'h0000_FFFF) | 32'hFFFF_0000) : (s & 32'h0000_FFFF);
    else if (op == 3'b100) return s & 32'h0000_00FF;
    else if (op == 3'b101) return s & 32'h0000_FFFF;
    else return w;
  endfunction

  // Response monitor: every rvalid must match the oldest prediction
  always @(negedge clk) begin
    exp_t e;
    if (bus.rvalid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check({e.tag, "_err"}, {31'd0, bus.err}, {31'd0, e.err});
        check({e.tag, "_data"}, bus.data_read, e.data);
      end
    end else if (bus.err) begin
      check("err_without_rvalid", {31'd0, bus.err}, 32'd0);
    end
  end

  // Issue one request from an IDLE negedge and wait for its completion
  task automatic do_op(input string tag, input logic we, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wd, input logic hold);
    logic [9:0]  idx;
    logic [1:0]  off;
    logic        bad;
    logic [31:0] word;
    logic [31:0] mask;
    exp_t        e;
    int          lat;
    int          exp_lat;
    idx = addr[11:2];
    off = addr[1:0];
    bad = !(op inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) || (we && op[2]) ||
          ((op[1:0] == 2'b01) && off[0]) || ((op == 3'b010) && (off != 2'b00));
    e.tag = tag;
    e.err = bad;
    if (bad) begin
      exp_lat = 1;
    end else if (we) begin
      word = mdl[idx];
      if (op == 3'b010) begin
        exp_lat = 1;
        word = wd;
      end else if (op == 3'b000) begin
        exp_lat = 2;
        mask = 32'h0000_00FF << (8 * off);
        word = (word & ~mask) | ((wd & 32'h0000_00FF) << (8 * off));
      end else begin
        exp_lat = 2;
        mask = 32'h0000_FFFF << (16 * off[1]);
        word = (word & ~mask) | ((wd & 32'h0000_FFFF) << (16 * off[1]));
      end
      mdl[idx] = word;
    end else begin
      exp_lat = 2;
      last_load = mdl_load(mdl[idx], op, off);
    end
    e.data = last_load;
    check({tag, "_rdy"}, {31'd0, bus.ready}, 32'd1);
    sb_q.push_back(e);
    bus.req = 1'b1;
    bus.MemWe = we;
    bus.MemOp = op;
    bus.data_addr = addr;
    bus.data_write = wd;
    @(posedge clk);
    #1;
    if (!hold) bus.req = 1'b0;
    lat = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check({tag, "_busy"}, {31'd0, bus.ready}, 32'd0);
      if (bus.rvalid) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
    bus.req = 1'b0;
    @(negedge clk);
    if (hold) check({tag, "_single"}, {31'd0, bus.rvalid}, 32'd0);
  endtask

  logic [2:0] op_tbl [6];

  initial begin
    logic [31:0] r;
    n_cmp = 0;
    n_bad = 0;
    last_load = 32'h0;
    op_tbl = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
    // request held during reset must be ignored
    rst = 1'b1;
    bus.req = 1'b1;
    bus.MemWe = 1'b1;
    bus.MemOp = 3'b010;
    bus.data_addr = 32'h0000_0010;
    bus.data_write = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_data", bus.data_read, 32'h0);
    rst = 1'b0;
    bus.req = 1'b0;
    @(negedge clk);
    check("post_rst_quiet", {31'd0, bus.rvalid}, 32'd0);

    do_op("sw10", 1'b1, 3'b010, 32'h0000_0010, 32'h8899_AABB, 1'b0);
    do_op("lw10", 1'b0, 3'b010, 32'h0000_0010, 32'h0, 1'b0);
    check("lw10_hold", bus.data_read, 32'h8899_AABB);
    do_op("lb13", 1'b0, 3'b000, 32'h0000_0013, 32'h0, 1'b0);
    check("lb13_k", bus.data_read, 32'hFFFF_FF88);
    do_op("lbu13", 1'b0, 3'b100, 32'h0000_0013, 32'h0, 1'b0);
    check("lbu13_k", bus.data_read, 32'h0000_0088);
    do_op("lh12", 1'b0, 3'b001, 32'h0000_0012, 32'h0, 1'b0);
    check("lh12_k", bus.data_read, 32'hFFFF_8899);
    do_op("lhu10", 1'b0, 3'b101, 32'h0000_0010, 32'h0, 1'b0);
    check("lhu10_k", bus.data_read, 32'h0000_AABB);
    do_op("sb11", 1'b1, 3'b000, 32'h0000_0011, 32'h1234_56CC, 1'b0);
    check("sb11_keep", bus.data_read, 32'h0000_AABB);
    do_op("lw10b", 1'b0, 3'b010, 32'h0000_0010, 32'h0, 1'b0);
    check("lw10b_k", bus.data_read, 32'h8899_CCBB);
    do_op("sh12", 1'b1, 3'b001, 32'h0000_0012, 32'h0000_7777, 1'b0);
    do_op("lw10c", 1'b0, 3'b010, 32'h0000_0010, 32'h0, 1'b0);
    check("lw10c_k", bus.data_read, 32'h7777_CCBB);

    // rejected requests
    do_op("sw04", 1'b1, 3'b010, 32'h0000_0004, 32'h0102_0304, 1'b0);
    do_op("lw04", 1'b0, 3'b010, 32'h0000_0004, 32'h0, 1'b0);
    do_op("e_lw02", 1'b0, 3'b010, 32'h0000_0002, 32'h0, 1'b0);
    do_op("e_sh05", 1'b1, 3'b001, 32'h0000_0005, 32'h0000_5555, 1'b0);
    do_op("e_op3", 1'b0, 3'b011, 32'h0000_0004, 32'h0, 1'b0);
    do_op("e_sbu", 1'b1, 3'b100, 32'h0000_0004, 32'h0000_00EE, 1'b0);
    check("err_keep", bus.data_read, 32'h0102_0304);
    do_op("lw04b", 1'b0, 3'b010, 32'h0000_0004, 32'h0, 1'b0);
    check("lw04b_k", bus.data_read, 32'h0102_0304);

    // reset during MERGE of an aliased sb aborts it
    check("abt_rdy", {31'd0, bus.ready}, 32'd1);
    bus.req = 1'b1;
    bus.MemWe = 1'b1;
    bus.MemOp = 3'b000;
    bus.data_addr = 32'h0000_1011;
    bus.data_write = 32'h0000_00EE;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    @(negedge clk);
    check("abt_fetch_busy", {31'd0, bus.ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("abt_rvalid", {31'd0, bus.rvalid}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abt_ready", {31'd0, bus.ready}, 32'd1);
    check("abt_data", bus.data_read, 32'h0);
    rst = 1'b0;
    last_load = 32'h0;
    @(negedge clk);
    do_op("lw1010", 1'b0, 3'b010, 32'h0000_1010, 32'h0, 1'b0);
    check("lw1010_k", bus.data_read, 32'h7777_CCBB);

    // req held high across a load
    do_op("hold_lw", 1'b0, 3'b010, 32'h0000_0010, 32'h0, 1'b1);

    // random traffic over 8 words with random upper address bits
    for (int i = 0; i < 8; i++) begin
      do_op($sformatf("init%0d", i), 1'b1, 3'b010, 32'h0000_0100 + 32'(4 * i), $urandom(), 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      r = $urandom();
      do_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), op_tbl[$urandom_range(0, 5)],
            {r[31:12], 7'b0001000, r[4:0]}, $urandom(), 1'b0);
    end

    check("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have port clock, input, 1, single clock; all state updates on posedge clock.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high.
REQ-003 SHALL have port req, input, 1, CPU data-access request; accepted only when ready=1.
REQ-004 SHALL have port data_addr, input, 32, byte address; only bits [11:0] used, upper bits ignored (4 KiB wrap).
REQ-005 SHALL have port data_write, input, 32, store data, right-aligned (sb uses [7:0], sh uses [15:0]).
REQ-006 SHALL have port MemOp, input, 3, 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu; all others invalid.
REQ-007 SHALL have port MemWe, input, 1, 1=store, 0=load.
REQ-008 SHALL have port ready, output, 1, controller can accept a request this cycle.
REQ-009 SHALL have port data_read, output, 32, extended load result.
REQ-010 SHALL have port rvalid, output, 1, one-cycle completion pulse for every accepted request.
REQ-011 SHALL have port err, output, 1, qualifies rvalid; 1 = request rejected.

Function
REQ-012 SHALL contain 1024x32 word RAM, synchronous read, indexed by data_addr[11:2]; little-endian byte lanes.
REQ-013 SHALL implement FSM states IDLE, FETCH, LRESP, WRITE, MERGE, ERR; ready=1 only in IDLE.
REQ-014 SHALL, on req=1 in IDLE, latch address, data, MemOp, MemWe into request registers; req outside IDLE ignored, no effect.
REQ-015 SHALL flag misaligned: halfword op with addr[0]=1, word op with addr[1:0]!=0; invalid MemOp, or MemWe=1 with MemOp 100/101, also rejected.
REQ-016 SHALL route rejected request IDLE->ERR; ERR lasts one cycle, rvalid=1, err=1, RAM and data_read unchanged; then IDLE.
REQ-017 SHALL route load IDLE->FETCH->LRESP->IDLE; RAM read in FETCH; in LRESP rvalid=1, data_read updated same cycle.
REQ-018 SHALL select load byte addr[1:0] / halfword addr[1]; lb/lh sign-extend, lbu/lhu zero-extend, lw full word.
REQ-019 SHALL route sw IDLE->WRITE->IDLE; full word written at end of WRITE; rvalid=1 in WRITE.
REQ-020 SHALL route sb/sh IDLE->FETCH->MERGE->IDLE; MERGE replaces addressed lane(s) of fetched word, writes merged word at end of MERGE, rvalid=1 in MERGE; other lanes preserved.
REQ-021 SHALL give latency from accept edge: sw/err rvalid 1 cycle later, loads and sb/sh 2 cycles later.
REQ-022 SHALL hold data_read at last load result until next LRESP; stores and errors do not modify it.
REQ-023 SHALL keep rvalid and err 0 in all states not named above; err=0 whenever rvalid=0.
REQ-024 SHALL allow back-to-back requests: new req accepted in the IDLE cycle following any completion; read after write to same word returns written data.

Reset
REQ-025 SHALL, with reset=1 at posedge, force state IDLE, ready=1, rvalid=0, err=0, data_read=0, request registers 0.
REQ-026 SHALL abort in-flight operation on reset; no RAM write occurs at an edge where reset=1, even in WRITE/MERGE; no rvalid for aborted request.
REQ-027 SHALL ignore req in the reset cycle; RAM contents not cleared by reset.

Verification
REQ-028 SHALL verify: sw addr 0x10 data 0x8899AABB, then lw 0x10 -> rvalid 1 cycle after sw accept; lw rvalid 2 cycles after accept, data_read=0x8899AABB.
REQ-029 SHALL verify: after REQ-028, lb 0x13 -> 0xFFFFFF88; lbu 0x13 -> 0x00000088; lh 0x12 -> 0xFFFF8899; lhu 0x10 -> 0x0000AABB.
REQ-030 SHALL verify: sb 0x11 data 0x123456CC on word 0x8899AABB -> lw 0x10 = 0x8899CCBB; sh 0x12 data 0x7777 -> lw 0x10 = 0x7777CCBB.
REQ-031 SHALL verify: lw 0x02, sh 0x05, MemOp 011 -> each rvalid=1 err=1 one cycle after accept; word 0x04 unchanged; data_read unchanged.
REQ-032 SHALL verify: sb accepted, reset asserted in MERGE cycle -> no write, no rvalid, state IDLE, data_read=0; address 0x1010 aliases 0x010.
REQ-033 SHALL verify: req held high during FETCH/LRESP of a load -> no second acceptance until IDLE; ready low in FETCH, LRESP, WRITE, MERGE, ERR.
